// File: rtl/spi_slave_responder_if.sv
// -----------------------------------------------------------------------------
// spi_slave_responder_if
// Bundles the SPI pins and the byte-level TX/RX handshake of the SPI mode-0
// responder so the design and its surroundings share one connection object.
//
//   SS, SCLK, MOSI     : pins driven by the remote SPI master (asynchronous)
//   MISO, MISO_OE      : responder data out and its output enable
//   TX_DATA, TX_VALID  : next word offered by local logic
//   TX_READY           : holding register empty, a word may be offered
//   RX_DATA, RX_VALID  : last complete received word and its 1-cycle strobe
//   TX_UNDERRUN        : 1-cycle strobe, idle byte sent for lack of TX data
//   BUSY               : responder is selected and transferring
//
// The slave modport is the responder's view, the master modport is the view of
// everything around it (remote master pins plus local byte-level logic).
// -----------------------------------------------------------------------------
interface spi_slave_responder_if #(
    parameter int WIDTH = 8
);
    logic             SS;
    logic             SCLK;
    logic             MOSI;
    logic             MISO;
    logic             MISO_OE;
    logic [WIDTH-1:0] TX_DATA;
    logic             TX_VALID;
    logic             TX_READY;
    logic [WIDTH-1:0] RX_DATA;
    logic             RX_VALID;
    logic             TX_UNDERRUN;
    logic             BUSY;

    modport slave (
        input  SS, SCLK, MOSI, TX_DATA, TX_VALID,
        output MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, TX_UNDERRUN, BUSY
    );

    modport master (
        output SS, SCLK, MOSI, TX_DATA, TX_VALID,
        input  MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, TX_UNDERRUN, BUSY
    );
endinterface

// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
// SPI mode-0 (CPOL=0, CPHA=0) responder running on the 48 MHz system clock.
// The master's SS/SCLK/MOSI are oversampled through synchronisers; bytes are
// shifted in on MOSI and out on MISO, MSB first, and exchanged with local logic
// through a valid/ready TX holding register and an RX word/strobe pair.
//
// Ports:
//   CLK_48MHZ : system clock
//   RESET     : asynchronous, active-high reset
//   bus       : spi_slave_responder_if.slave (SPI pins + byte handshake)
// Parameters:
//   WIDTH     : bits per SPI word (>= 3)
//   IDLE_BYTE : word shifted out when no TX word is waiting
// -----------------------------------------------------------------------------
module spi_slave_responder #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_BYTE = '0
) (
    input logic                  CLK_48MHZ,
    input logic                  RESET,
    spi_slave_responder_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t           state_q,    state_d;
    logic [CW-1:0]    bitCount_q, bitCount_d;
    logic [WIDTH-2:0] rxShift_q,  rxShift_d;
    logic [WIDTH-1:0] rxData_q,   rxData_d;
    logic             rxValid_q,  rxValid_d;
    logic [WIDTH-1:0] txHold_q,   txHold_d;
    logic             txFull_q,   txFull_d;
    logic [WIDTH-1:0] txShift_q,  txShift_d;
    logic             underrun_q, underrun_d;

    logic [2:0]       ssSync_q;
    logic [2:0]       sclkSync_q;
    logic [1:0]       mosiSync_q;

    logic             ssS2;
    logic             ssFall;
    logic             ssRise;
    logic             sclkRise;
    logic             sclkFall;
    logic             mosiS2;
    logic             wordStart;

    // Two-flop synchronisers for the asynchronous master pins. SS and SCLK keep
    // a third history flop so their edges can be found by comparing s2 with s3;
    // MOSI is only ever sampled as a level, so it needs no history. The SS
    // chain resets high so that coming out of reset never looks like a select.
    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            ssSync_q   <= 3'b111;
            sclkSync_q <= 3'b000;
            mosiSync_q <= 2'b00;
        end else begin
            ssSync_q   <= {ssSync_q[1:0], bus.SS};
            sclkSync_q <= {sclkSync_q[1:0], bus.SCLK};
            mosiSync_q <= {mosiSync_q[0], bus.MOSI};
        end
    end

    assign ssS2     = ssSync_q[1];
    assign ssFall   = !ssSync_q[1] && ssSync_q[2];
    assign ssRise   = ssSync_q[1] && !ssSync_q[2];
    assign sclkRise = sclkSync_q[1] && !sclkSync_q[2];
    assign sclkFall = !sclkSync_q[1] && sclkSync_q[2];
    assign mosiS2   = mosiSync_q[1];

    // State register for the FSM and the whole datapath. Everything returns to
    // its idle value on reset, including emptying the TX holding register.
    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            bitCount_q <= '0;
            rxShift_q  <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            txHold_q   <= '0;
            txFull_q   <= 1'b0;
            txShift_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCount_q <= bitCount_d;
            rxShift_q  <= rxShift_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            txHold_q   <= txHold_d;
            txFull_q   <= txFull_d;
            txShift_q  <= txShift_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state logic. A word start happens on select and again on the first
    // SCLK falling edge after a word completes, which is what lets the master
    // stream words back-to-back under one SS low. SCLK edges are only honoured
    // while selected and never in the cycle SS changes, so a master that drops
    // SCLK and raises SS together ends cleanly without a spurious word start.
    // Losing select mid-word simply drops the partial RX word; the TX word that
    // was already loaded is considered consumed.
    always_comb begin
        state_d    = state_q;
        bitCount_d = bitCount_q;
        rxShift_d  = rxShift_q;
        rxData_d   = rxData_q;
        rxValid_d  = 1'b0;
        txHold_d   = txHold_q;
        txFull_d   = txFull_q;
        txShift_d  = txShift_q;
        underrun_d = 1'b0;
        wordStart  = 1'b0;

        if (bus.TX_VALID && !txFull_q) begin
            txHold_d = bus.TX_DATA;
            txFull_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ssFall) begin
                    state_d    = ACTIVE;
                    bitCount_d = '0;
                    wordStart  = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssRise) begin
                    state_d    = IDLE;
                    bitCount_d = '0;
                end else if (!ssS2) begin
                    if (sclkRise) begin
                        rxShift_d = {rxShift_q[WIDTH-3:0], mosiS2};
                        if (bitCount_q == LAST_BIT) begin
                            rxData_d   = {rxShift_q, mosiS2};
                            rxValid_d  = 1'b1;
                            bitCount_d = '0;
                        end else begin
                            bitCount_d = bitCount_q + 1'b1;
                        end
                    end else if (sclkFall) begin
                        if (bitCount_q == '0) begin
                            wordStart = 1'b1;
                        end else begin
                            txShift_d = {txShift_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The holding register is drained into the shifter at every word start;
        // if it is empty the idle byte goes out instead and the underrun strobe
        // tells local logic it fell behind. A load and a drain never coincide
        // because loads are only accepted while the register is empty.
        if (wordStart) begin
            if (txFull_q) begin
                txShift_d = txHold_q;
                txFull_d  = 1'b0;
            end else begin
                txShift_d  = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end
    end

    // MISO follows the shifter MSB but is forced low whenever not selected.
    assign bus.MISO        = (state_q == ACTIVE) && txShift_q[WIDTH-1];
    assign bus.MISO_OE     = (state_q == ACTIVE);
    assign bus.BUSY        = (state_q == ACTIVE);
    assign bus.TX_READY    = !txFull_q;
    assign bus.RX_DATA     = rxData_q;
    assign bus.RX_VALID    = rxValid_q;
    assign bus.TX_UNDERRUN = underrun_q;
endmodule

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_responder
// Drives the responder as a 2 MHz mode-0 SPI master (12 system cycles per SCLK
// phase) while feeding the TX holding register, and compares MISO bytes, RX
// words, strobe counts and status outputs against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;

    spi_slave_responder_if #(.WIDTH(8)) bus ();

    spi_slave_responder #(
        .WIDTH     (8),
        .IDLE_BYTE (8'h00)
    ) dut (
        .CLK_48MHZ (clock),
        .RESET     (reset),
        .bus       (bus)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic       loadTx;
        logic [7:0] txByte;
        logic [7:0] mosiByte;
        logic [7:0] expMiso;
        logic [7:0] expRx;
        int         expUnderrun;
    } vector_t;

    vector_t    vectors [4];
    int         nCompared     = 0;
    int         nMismatched   = 0;
    int         rxCount       = 0;
    int         underrunCount = 0;
    int         widthErrors   = 0;
    logic [7:0] rxLog [$];
    logic       prevRxValid   = 1'b0;
    logic       prevUnderrun  = 1'b0;
    logic [7:0] mosiWords [4];
    logic [7:0] misoWords [4];

    // Strobe monitor: logs every RX word, counts underrun pulses and flags any
    // strobe that stays high for more than one cycle.
    always @(negedge clock) begin
        if (bus.RX_VALID === 1'b1) begin
            rxCount++;
            rxLog.push_back(bus.RX_DATA);
        end
        if (bus.TX_UNDERRUN === 1'b1) begin
            underrunCount++;
        end
        if ((bus.RX_VALID && prevRxValid) || (bus.TX_UNDERRUN && prevUnderrun)) begin
            widthErrors++;
        end
        prevRxValid  = bus.RX_VALID;
        prevUnderrun = bus.TX_UNDERRUN;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic loadTx(input logic [7:0] value);
        int guard;
        guard = 0;
        while (bus.TX_READY !== 1'b1 && guard < 2000) begin
            waitCycles(1);
            guard++;
        end
        if (guard >= 2000) begin
            checkOutput("loadTx ready timeout", 32'(bus.TX_READY), 32'd1);
        end
        bus.TX_DATA  = value;
        bus.TX_VALID = 1'b1;
        waitCycles(1);
        bus.TX_VALID = 1'b0;
    endtask

    // One SCLK period: MOSI set up in the low phase, MISO sampled just before
    // the rising edge; optionally SS is released together with the falling edge.
    task automatic spiBit(input logic mosiBit, input logic releaseSs, output logic misoBit);
        bus.MOSI = mosiBit;
        waitCycles(6);
        misoBit  = bus.MISO;
        bus.SCLK = 1'b1;
        waitCycles(12);
        bus.SCLK = 1'b0;
        if (releaseSs) begin
            bus.SS = 1'b1;
        end
        waitCycles(6);
    endtask

    task automatic spiTransfer(input int nWords, input int lastBits);
        logic bitOut;
        bus.SS = 1'b0;
        waitCycles(6);
        for (int w = 0; w < nWords; w++) begin
            int nb;
            nb = (w == nWords - 1) ? lastBits : 8;
            misoWords[w] = 8'h00;
            for (int b = 0; b < nb; b++) begin
                spiBit(mosiWords[w][7-b], (w == nWords - 1) && (b == nb - 1), bitOut);
                misoWords[w][7-b] = bitOut;
            end
        end
        waitCycles(10);
    endtask

    task automatic applyStimulus(input vector_t v, input int idx);
        int rx0;
        int u0;
        rx0 = rxCount;
        u0  = underrunCount;
        if (v.loadTx) begin
            loadTx(v.txByte);
            checkOutput($sformatf("vec%0d tx ready after load", idx), 32'(bus.TX_READY), 32'd0);
        end
        mosiWords[0] = v.mosiByte;
        spiTransfer(1, 8);
        checkOutput($sformatf("vec%0d miso byte", idx), 32'(misoWords[0]), 32'(v.expMiso));
        checkOutput($sformatf("vec%0d rx count", idx), 32'(rxCount - rx0), 32'd1);
        checkOutput($sformatf("vec%0d rx data", idx), 32'(bus.RX_DATA), 32'(v.expRx));
        checkOutput($sformatf("vec%0d underrun count", idx), 32'(underrunCount - u0), 32'(v.expUnderrun));
        checkOutput($sformatf("vec%0d tx ready", idx), 32'(bus.TX_READY), 32'd1);
        checkOutput($sformatf("vec%0d busy", idx), 32'(bus.BUSY), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " miso"}, 32'(bus.MISO), 32'd0);
        checkOutput({tag, " miso_oe"}, 32'(bus.MISO_OE), 32'd0);
        checkOutput({tag, " tx_ready"}, 32'(bus.TX_READY), 32'd1);
        checkOutput({tag, " rx_data"}, 32'(bus.RX_DATA), 32'd0);
        checkOutput({tag, " rx_valid"}, 32'(bus.RX_VALID), 32'd0);
        checkOutput({tag, " tx_underrun"}, 32'(bus.TX_UNDERRUN), 32'd0);
        checkOutput({tag, " busy"}, 32'(bus.BUSY), 32'd0);
    endtask

    initial begin
        int   rx0;
        int   u0;
        int   guard;
        logic bitOut;
        logic [2:0] firstBits;

        bus.SS       = 1'b1;
        bus.SCLK     = 1'b0;
        bus.MOSI     = 1'b0;
        bus.TX_DATA  = 8'h00;
        bus.TX_VALID = 1'b0;

        vectors[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vectors[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1};
        vectors[2] = '{1'b1, 8'h81, 8'h00, 8'h81, 8'h00, 0};
        vectors[3] = '{1'b1, 8'h7E, 8'h5A, 8'h7E, 8'h5A, 0};

        #1 reset = 1'b1;
        waitCycles(3);
        checkResetValues("reset");
        reset = 1'b0;
        waitCycles(5);

        $display("[TB] table-driven single-word transfers");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i], i);
        end

        $display("[TB] three back-to-back words under one select");
        loadTx(8'h11);
        mosiWords[0] = 8'hA1;
        mosiWords[1] = 8'hB2;
        mosiWords[2] = 8'hC3;
        rx0 = rxLog.size();
        u0  = underrunCount;
        fork
            spiTransfer(3, 8);
            begin
                loadTx(8'h22);
                loadTx(8'h33);
            end
        join
        checkOutput("b2b miso word0", 32'(misoWords[0]), 32'h11);
        checkOutput("b2b miso word1", 32'(misoWords[1]), 32'h22);
        checkOutput("b2b miso word2", 32'(misoWords[2]), 32'h33);
        checkOutput("b2b rx count", 32'(rxLog.size() - rx0), 32'd3);
        checkOutput("b2b rx word0", 32'(rxLog[rx0]), 32'hA1);
        checkOutput("b2b rx word1", 32'(rxLog[rx0+1]), 32'hB2);
        checkOutput("b2b rx word2", 32'(rxLog[rx0+2]), 32'hC3);
        checkOutput("b2b underrun count", 32'(underrunCount - u0), 32'd0);

        $display("[TB] select released after five bits");
        rx0 = rxCount;
        u0  = underrunCount;
        mosiWords[0] = 8'h81;
        spiTransfer(1, 5);
        checkOutput("abort rx count", 32'(rxCount - rx0), 32'd0);
        checkOutput("abort busy", 32'(bus.BUSY), 32'd0);
        checkOutput("abort miso_oe", 32'(bus.MISO_OE), 32'd0);
        checkOutput("abort miso", 32'(bus.MISO), 32'd0);
        checkOutput("abort underrun count", 32'(underrunCount - u0), 32'd1);
        rx0 = rxCount;
        loadTx(8'hC3);
        mosiWords[0] = 8'h7E;
        spiTransfer(1, 8);
        checkOutput("after abort rx count", 32'(rxCount - rx0), 32'd1);
        checkOutput("after abort rx data", 32'(bus.RX_DATA), 32'h7E);
        checkOutput("after abort miso", 32'(misoWords[0]), 32'hC3);

        $display("[TB] reset asserted during bit four");
        rx0 = rxCount;
        loadTx(8'h96);
        bus.SS = 1'b0;
        waitCycles(6);
        for (int b = 0; b < 3; b++) begin
            spiBit(1'b1, 1'b0, bitOut);
            firstBits[2-b] = bitOut;
        end
        checkOutput("reset test first bits", 32'(firstBits), 32'h4);
        loadTx(8'h44);
        checkOutput("reset test holding full", 32'(bus.TX_READY), 32'd0);
        bus.MOSI = 1'b0;
        waitCycles(6);
        bus.SCLK = 1'b1;
        waitCycles(4);
        reset = 1'b1;
        #2;
        checkResetValues("mid-transfer reset");
        bus.SCLK = 1'b0;
        bus.SS   = 1'b1;
        waitCycles(3);
        reset = 1'b0;
        waitCycles(10);
        checkOutput("reset test rx count", 32'(rxCount - rx0), 32'd0);
        rx0 = rxCount;
        loadTx(8'h3C);
        mosiWords[0] = 8'hE7;
        spiTransfer(1, 8);
        checkOutput("post reset miso", 32'(misoWords[0]), 32'h3C);
        checkOutput("post reset rx data", 32'(bus.RX_DATA), 32'hE7);
        checkOutput("post reset rx count", 32'(rxCount - rx0), 32'd1);

        $display("[TB] TX_VALID held while holding register full");
        rx0 = rxLog.size();
        u0  = underrunCount;
        bus.TX_DATA  = 8'h5A;
        bus.TX_VALID = 1'b1;
        waitCycles(1);
        bus.TX_DATA  = 8'h6B;
        waitCycles(2);
        checkOutput("held ready low", 32'(bus.TX_READY), 32'd0);
        mosiWords[0] = 8'h12;
        mosiWords[1] = 8'h34;
        fork
            spiTransfer(2, 8);
            begin
                guard = 0;
                while (bus.TX_READY !== 1'b1 && guard < 3000) begin
                    waitCycles(1);
                    guard++;
                end
                checkOutput("held ready rise seen", 32'(bus.TX_READY), 32'd1);
                waitCycles(1);
                bus.TX_VALID = 1'b0;
                checkOutput("held second accepted", 32'(bus.TX_READY), 32'd0);
            end
        join
        checkOutput("held miso word0", 32'(misoWords[0]), 32'h5A);
        checkOutput("held miso word1", 32'(misoWords[1]), 32'h6B);
        checkOutput("held rx count", 32'(rxLog.size() - rx0), 32'd2);
        checkOutput("held rx word0", 32'(rxLog[rx0]), 32'h12);
        checkOutput("held rx word1", 32'(rxLog[rx0+1]), 32'h34);
        checkOutput("held underrun count", 32'(underrunCount - u0), 32'd0);

        checkOutput("strobe width errors", 32'(widthErrors), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
